hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline control block for the 5-stage core. It sequences the stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) through their `en` (stall) and flush inputs, and drives the EX-stage forwarding selects. It resolves three conditions:
- load-use hazards, with a parameterised bubble count;
- taken-branch flushes;
- data-memory wait handshakes, with timeout detection.

It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- `RW`, default 4: register-number width.
- `LOAD_BUBBLES`, default 1: bubbles inserted per load-use hazard (1..15).
- `TIMEOUT`, default 64: memory-wait cycles before `memTimeout` sets (2..255).
- `CNTW`, default 16: width of the stall counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `raId`, `rbId`, `rcId` input RW each: source registers of the instruction in ID.
- `useAId`, `useBId`, `useCId` input 1 each: the ID instruction actually reads that source.
- `raEx`, `rbEx`, `rcSrcEx` input RW each: source registers of the instruction in EX.
- `rcEx` input RW: destination register in EX.
- `regWriteEx`, `memToRegEx` input 1 each: EX-stage control bits.
- `rcMem` input RW, `regWriteMem` input 1: MEM-stage destination.
- `rcWb` input RW, `regWriteWb` input 1: WB-stage destination.
- `branchTakenEx` input 1: branch resolved taken in EX this cycle.
- `memReq` input 1: a load or store occupies MEM.
- `memReady` input 1: data memory completes this cycle.
- `enPc`, `enIfId`, `enIdEx`, `enExMem`, `enMemWb` output 1 each: stage enables; 1 = advance.
- `flushIfId`, `flushIdEx` output 1 each: synchronous clear of that buffer on this edge.
- `fwdA`, `fwdB`, `fwdC` output 2 each: EX operand select. 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- `memTimeout` output 1: sticky error flag.
- `stallCycles` output CNTW: saturating count of frozen or bubbled cycles.

## Operation
Register 0 is an ordinary register; it gets no special-casing in any comparison.

**Forwarding (combinational, independent of state)**
- For each of A, B, C: the select is 01 if `regWriteMem` and `rcMem` equals the EX source.
- Otherwise it is 10 if `regWriteWb` and `rcWb` matches.
- Otherwise it is 00. The MEM stage wins when both MEM and WB match.

**Hazard term**
- `memHold` = `memReq` & !`memReady`.
- `luHaz` = `regWriteEx` & `memToRegEx` & (any used ID source equals `rcEx`).

**FSM states: RUN, LU_STALL, MEM_WAIT**
- **RUN**
  - If `memHold`: all enables 0, no flush, go to MEM_WAIT, load the wait counter with 1.
  - Else if `branchTakenEx`: all enables 1, `flushIfId` = `flushIdEx` = 1, stay in RUN. A branch outranks `luHaz`.
  - Else if `luHaz`: `enPc` = `enIfId` = 0, other enables 1, `flushIdEx` = 1. If LOAD_BUBBLES > 1, go to LU_STALL with the bubble counter set to LOAD_BUBBLES−1.
  - Else: all enables 1, no flush.
- **LU_STALL**
  - Outputs are the same as the `luHaz` case. The bubble counter decrements each cycle and the FSM returns to RUN after the cycle in which the counter equals 1.
  - If `memHold` is high: all enables 0, no flush, and both the state and the counter are frozen.
- **MEM_WAIT**
  - While `memHold`: all enables 0, the wait counter increments (saturating), and `memTimeout` sets when the count reaches TIMEOUT.
  - When `memReady` = 1: all enables 1 and go to RUN. Branch and load-use terms are evaluated as in RUN in that same cycle.
- `memTimeout` is cleared only by reset.

**Stall counter**
- `stallCycles` increments on every cycle in which any enable is 0.
- It saturates at 2^CNTW−1.

## Timing
- Reset (async assert, `rst` = 0):
  - state = RUN; bubble counter and wait counter = 0;
  - `stallCycles` = 0, `memTimeout` = 0;
  - the outputs then follow RUN with all inputs low: enables 1, flushes 0, fwd 00.
- Reset release is synchronous to `clk`. Reset asserted mid-stall aborts the stall immediately.
- All enable, flush and fwd outputs are combinational from the current state and inputs. They take effect at the next rising edge, with zero added latency.
- Load-use penalty is exactly LOAD_BUBBLES cycles of `enPc` = 0.
- A branch costs 2 flushed slots and no freeze.
- Memory-wait adds N frozen cycles, where N is the number of cycles `memReady` stays low while `memReq` is high.
- `stallCycles` and `memTimeout` update on the edge following the qualifying cycle.

## Test plan
- **Forwarding.** Drive `raEx` = 3, `rcMem` = 3, `regWriteMem` = 1, `rcWb` = 3, `regWriteWb` = 1 → `fwdA` = 01. Then drop `regWriteMem` → `fwdA` = 10. Then set `rcWb` = 4 → `fwdA` = 00.
- **Load-use bubbles.** LOAD_BUBBLES = 2, `rcEx` = 5, `memToRegEx` = `regWriteEx` = 1, `raId` = 5, `useAId` = 1 → `enPc` is 0 for exactly 2 cycles, `flushIdEx` is 1 on both, and `stallCycles` = 2.
- **Branch vs. load-use.** Assert `branchTakenEx` together with `luHaz` → both flushes are 1, all enables are 1, and the FSM stays in RUN.
- **Memory wait.** Raise `memReq` with `memReady` low for 3 cycles, then high → all enables 0 for 3 cycles and 1 on the 4th, `memTimeout` = 0, `stallCycles` = 3.
- **Timeout.** TIMEOUT = 4, hold `memHold` for 6 cycles → `memTimeout` rises after the 4th wait cycle and stays 1 after `memReady` until `rst` = 0.
- **Reset mid-stall.** Pull `rst` low during LU_STALL → immediately all enables 1, `stallCycles` = 0, state RUN.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: load-use bubbles, branch flushes, memory-wait freeze
// with timeout, EX operand forwarding and a saturating stall-cycle counter.
module hazard_sequencer #(
  parameter int unsigned RW           = 4,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CNTW         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   raId,
  input  logic [RW-1:0]   rbId,
  input  logic [RW-1:0]   rcId,
  input  logic            useAId,
  input  logic            useBId,
  input  logic            useCId,
  input  logic [RW-1:0]   raEx,
  input  logic [RW-1:0]   rbEx,
  input  logic [RW-1:0]   rcSrcEx,
  input  logic [RW-1:0]   rcEx,
  input  logic            regWriteEx,
  input  logic            memToRegEx,
  input  logic [RW-1:0]   rcMem,
  input  logic            regWriteMem,
  input  logic [RW-1:0]   rcWb,
  input  logic            regWriteWb,
  input  logic            branchTakenEx,
  input  logic            memReq,
  input  logic            memReady,
  output logic            enPc,
  output logic            enIfId,
  output logic            enIdEx,
  output logic            enExMem,
  output logic            enMemWb,
  output logic            flushIfId,
  output logic            flushIdEx,
  output logic [1:0]      fwdA,
  output logic [1:0]      fwdB,
  output logic [1:0]      fwdC,
  output logic            memTimeout,
  output logic [CNTW-1:0] stallCycles
);

  localparam int unsigned BW = 4;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} stateT;

  stateT          state, stateNext;
  logic [BW-1:0]  bubbleCnt, bubbleNext;
  logic [WW-1:0]  waitCnt, waitNext;
  logic           timeoutNext;
  logic           memHold, luHaz, anyStall;

  assign memHold = memReq & ~memReady;
  assign luHaz   = regWriteEx & memToRegEx &
                   ((useAId & (raId == rcEx)) |
                    (useBId & (rbId == rcEx)) |
                    (useCId & (rcId == rcEx)));

  // MEM/WB priority select; register 0 is compared like any other
  function automatic logic [1:0] fwdSel(input logic [RW-1:0] src);
    if (regWriteMem && (rcMem == src)) return 2'b01;
    if (regWriteWb && (rcWb == src))   return 2'b10;
    return 2'b00;
  endfunction

  assign fwdA = fwdSel(raEx);
  assign fwdB = fwdSel(rbEx);
  assign fwdC = fwdSel(rcSrcEx);

  always_comb begin
    stateNext   = state;
    bubbleNext  = bubbleCnt;
    waitNext    = waitCnt;
    timeoutNext = memTimeout;
    enPc        = 1'b1;
    enIfId      = 1'b1;
    enIdEx      = 1'b1;
    enExMem     = 1'b1;
    enMemWb     = 1'b1;
    flushIfId   = 1'b0;
    flushIdEx   = 1'b0;
    case (state)
      LU_STALL: begin
        if (memHold) begin
          {enPc, enIfId, enIdEx, enExMem, enMemWb} = 5'b00000;
        end else begin
          enPc       = 1'b0;
          enIfId     = 1'b0;
          flushIdEx  = 1'b1;
          bubbleNext = bubbleCnt - BW'(1);
          if (bubbleCnt == BW'(1)) stateNext = RUN;
        end
      end
      default: begin
        if (memHold) begin
          {enPc, enIfId, enIdEx, enExMem, enMemWb} = 5'b00000;
          if (state == RUN) begin
            stateNext = MEM_WAIT;
            waitNext  = WW'(1);
          end else begin
            if (waitCnt != {WW{1'b1}}) waitNext = waitCnt + WW'(1);
            if ((9'(waitCnt) + 9'd1) >= 9'(TIMEOUT)) timeoutNext = 1'b1;
          end
        end else begin
          // memory released (or idle): resolve branch / load-use as in RUN
          stateNext = RUN;
          if (branchTakenEx) begin
            flushIfId = 1'b1;
            flushIdEx = 1'b1;
          end else if (luHaz) begin
            enPc      = 1'b0;
            enIfId    = 1'b0;
            flushIdEx = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              stateNext  = LU_STALL;
              bubbleNext = BW'(LOAD_BUBBLES - 1);
            end
          end
        end
      end
    endcase
  end

  assign anyStall = ~(enPc & enIfId & enIdEx & enExMem & enMemWb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      bubbleCnt   <= '0;
      waitCnt     <= '0;
      memTimeout  <= 1'b0;
      stallCycles <= '0;
    end else begin
      state      <= stateNext;
      bubbleCnt  <= bubbleNext;
      waitCnt    <= waitNext;
      memTimeout <= timeoutNext;
      if (anyStall && (stallCycles != {CNTW{1'b1}}))
        stallCycles <= stallCycles + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized and directed check of hazard_sequencer against a cycle-level
// behavioural model of the pipeline control rules.
module tb_hazard_sequencer;

  localparam int unsigned RW   = 4;
  localparam int unsigned LB   = 2;
  localparam int unsigned TO   = 4;
  localparam int unsigned CNTW = 6;
  localparam int SMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [RW-1:0] raId, rbId, rcId, raEx, rbEx, rcSrcEx, rcEx, rcMem, rcWb;
  logic useAId, useBId, useCId, regWriteEx, memToRegEx, regWriteMem, regWriteWb;
  logic branchTakenEx, memReq, memReady;
  logic enPc, enIfId, enIdEx, enExMem, enMemWb, flushIfId, flushIdEx, memTimeout;
  logic [1:0] fwdA, fwdB, fwdC;
  logic [CNTW-1:0] stallCycles;

  int total = 0;
  int bad   = 0;

  // model state
  int luRemain  = 0;
  bit inWait    = 0;
  int waitCount = 0;
  bit toFlag    = 0;
  int stalls    = 0;

  hazard_sequencer #(.RW(RW), .LOAD_BUBBLES(LB), .TIMEOUT(TO), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .raId(raId), .rbId(rbId), .rcId(rcId),
    .useAId(useAId), .useBId(useBId), .useCId(useCId),
    .raEx(raEx), .rbEx(rbEx), .rcSrcEx(rcSrcEx), .rcEx(rcEx),
    .regWriteEx(regWriteEx), .memToRegEx(memToRegEx),
    .rcMem(rcMem), .regWriteMem(regWriteMem),
    .rcWb(rcWb), .regWriteWb(regWriteWb),
    .branchTakenEx(branchTakenEx), .memReq(memReq), .memReady(memReady),
    .enPc(enPc), .enIfId(enIfId), .enIdEx(enIdEx), .enExMem(enExMem), .enMemWb(enMemWb),
    .flushIfId(flushIfId), .flushIdEx(flushIdEx),
    .fwdA(fwdA), .fwdB(fwdB), .fwdC(fwdC),
    .memTimeout(memTimeout), .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] expFwd(input logic [RW-1:0] src);
    if (regWriteMem && rcMem == src) return 2'b01;
    if (regWriteWb && rcWb == src)   return 2'b10;
    return 2'b00;
  endfunction

  task automatic clearInputs();
    {raId, rbId, rcId, raEx, rbEx, rcSrcEx, rcEx, rcMem, rcWb} = '0;
    {useAId, useBId, useCId, regWriteEx, memToRegEx, regWriteMem, regWriteWb} = '0;
    {branchTakenEx, memReq, memReady} = '0;
  endtask

  task automatic modelReset();
    luRemain = 0; inWait = 0; waitCount = 0; toFlag = 0; stalls = 0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    clearInputs();
    modelReset();
    #1;
    checkVal("rst_stall", 32'(stallCycles), 0);
    checkVal("rst_timeout", 32'(memTimeout), 0);
    checkVal("rst_en", 32'({enPc, enIfId, enIdEx, enExMem, enMemWb}), 32'h1f);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // one clock: predict, check combinational outputs mid-cycle, then registered ones
  task automatic step();
    bit hold, lu;
    logic [4:0] en;
    logic [1:0] fl;
    hold = memReq && !memReady;
    lu = regWriteEx && memToRegEx &&
         ((useAId && raId == rcEx) || (useBId && rbId == rcEx) || (useCId && rcId == rcEx));
    en = 5'b11111;
    fl = 2'b00;
    if (hold) begin
      en = 5'b00000;
      if (luRemain == 0) begin
        if (!inWait) begin
          inWait = 1; waitCount = 1;
        end else begin
          if (waitCount < 255) waitCount++;
          if (waitCount >= TO) toFlag = 1;
        end
      end
    end else if (luRemain > 0) begin
      en = 5'b00111; fl = 2'b01; luRemain--;
    end else begin
      inWait = 0;
      if (branchTakenEx) fl = 2'b11;
      else if (lu) begin
        en = 5'b00111; fl = 2'b01; luRemain = LB - 1;
      end
    end
    if (en != 5'b11111 && stalls < SMAX) stalls++;
    @(negedge clk);
    checkVal("enables", 32'({enPc, enIfId, enIdEx, enExMem, enMemWb}), 32'(en));
    checkVal("flushes", 32'({flushIfId, flushIdEx}), 32'(fl));
    checkVal("fwdA", 32'(fwdA), 32'(expFwd(raEx)));
    checkVal("fwdB", 32'(fwdB), 32'(expFwd(rbEx)));
    checkVal("fwdC", 32'(fwdC), 32'(expFwd(rcSrcEx)));
    @(posedge clk); #1;
    checkVal("stallCycles", 32'(stallCycles), 32'(stalls));
    checkVal("memTimeout", 32'(memTimeout), 32'(toFlag));
  endtask

  initial begin
    clearInputs();
    doReset();

    // forwarding priority
    raEx = 4'd3; rcMem = 4'd3; regWriteMem = 1; rcWb = 4'd3; regWriteWb = 1;
    #1 checkVal("fwd_mem", 32'(fwdA), 32'h1);
    regWriteMem = 0;
    #1 checkVal("fwd_wb", 32'(fwdA), 32'h2);
    rcWb = 4'd4;
    #1 checkVal("fwd_none", 32'(fwdA), 32'h0);
    step();

    // load-use: two bubbles
    doReset();
    rcEx = 4'd5; memToRegEx = 1; regWriteEx = 1; raId = 4'd5; useAId = 1;
    step();
    clearInputs();
    step();
    step();
    checkVal("lu_stalls", 32'(stallCycles), 32'd2);

    // branch outranks load-use
    doReset();
    rcEx = 4'd5; memToRegEx = 1; regWriteEx = 1; raId = 4'd5; useAId = 1; branchTakenEx = 1;
    step();
    clearInputs();
    step();
    checkVal("br_stalls", 32'(stallCycles), 32'd0);

    // memory wait of 3 cycles
    doReset();
    memReq = 1;
    repeat (3) step();
    memReady = 1;
    step();
    checkVal("mw_stalls", 32'(stallCycles), 32'd3);
    checkVal("mw_timeout", 32'(memTimeout), 32'd0);

    // timeout after the 4th wait cycle, sticky until reset
    doReset();
    memReq = 1;
    repeat (3) step();
    checkVal("to_before", 32'(memTimeout), 32'd0);
    step();
    checkVal("to_set", 32'(memTimeout), 32'd1);
    repeat (2) step();
    memReady = 1;
    step();
    clearInputs();
    step();
    checkVal("to_sticky", 32'(memTimeout), 32'd1);

    // reset in the middle of a load-use stall
    doReset();
    rcEx = 4'd5; memToRegEx = 1; regWriteEx = 1; rbId = 4'd5; useBId = 1;
    step();
    clearInputs();
    #2 rst = 1'b0;
    modelReset();
    #1;
    checkVal("mid_rst_en", 32'({enPc, enIfId, enIdEx, enExMem, enMemWb}), 32'h1f);
    checkVal("mid_rst_flush", 32'({flushIfId, flushIdEx}), 32'h0);
    checkVal("mid_rst_stall", 32'(stallCycles), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      raId = RW'($urandom_range(0, 3)); rbId = RW'($urandom_range(0, 3));
      rcId = RW'($urandom_range(0, 3)); rcEx = RW'($urandom_range(0, 3));
      raEx = RW'($urandom_range(0, 3)); rbEx = RW'($urandom_range(0, 3));
      rcSrcEx = RW'($urandom_range(0, 3));
      rcMem = RW'($urandom_range(0, 3)); rcWb = RW'($urandom_range(0, 3));
      useAId = 1'($urandom); useBId = 1'($urandom); useCId = 1'($urandom);
      regWriteEx = 1'($urandom); memToRegEx = 1'($urandom);
      regWriteMem = 1'($urandom); regWriteWb = 1'($urandom);
      branchTakenEx = ($urandom_range(0, 7) == 0);
      memReq = ($urandom_range(0, 3) == 0);
      memReady = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
